inst_encoder_loader: RTL and testbench

Streams decoded RISC-V instruction fields (format, opcode, registers, functs, signed immediate) and packs each one into a 32-bit RV32I instruction word. This is the inverse of the core's immediate extraction path. Each packed word is written sequentially into instruction memory through a valid/ready write port. The block sits between the test/BIOS program feeder and IMEM. It range-checks immediates, tracks the write address, and stops when memory is full.

---
 rtl/riscv_enc_pkg.sv | 53 +++++
 rtl/inst_field_pack.sv | 55 +++++
 rtl/inst_encoder_loader.sv | 127 ++++++++++++
 tb/tb_inst_encoder_loader.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder/loader.
package riscv_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_RANGE = 2'd1;
    localparam logic [1:0] ERR_FMT   = 2'd2;
    localparam logic [1:0] ERR_ALIGN = 2'd3;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    localparam int IMM_I_MIN = -2048;
    localparam int IMM_I_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;
    localparam int IMM_J_MIN = -1048576;
    localparam int IMM_J_MAX = 1048574;

    // One decoded instruction's fields as presented on the input stream.
    typedef struct packed {
        logic [31:0] imm;
        logic [6:0]  funct7;
        logic [4:0]  rs2;
        logic [4:0]  rs1;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [6:0]  opcode;
    } inst_fields_t;

endpackage

// File: rtl/inst_field_pack.sv
// Combinational packer: decoded fields + format -> RV32I word, with
// immediate range/alignment and reserved-format flags.
module inst_field_pack
    import riscv_enc_pkg::*;
(
    input  logic [2:0]   fmt,
    input  inst_fields_t fields,
    output logic [31:0]  word,
    output logic         fmt_bad,
    output logic         range_bad,
    output logic         align_bad
);

    logic signed [31:0] simm;
    assign simm = $signed(fields.imm);

    always_comb begin
        word      = '0;
        fmt_bad   = 1'b0;
        range_bad = 1'b0;
        align_bad = 1'b0;
        case (fmt)
            FMT_R: word = {fields.funct7, fields.rs2, fields.rs1, fields.funct3,
                           fields.rd, fields.opcode};
            FMT_I: begin
                word      = {fields.imm[11:0], fields.rs1, fields.funct3, fields.rd,
                             fields.opcode};
                range_bad = (simm < IMM_I_MIN) || (simm > IMM_I_MAX);
            end
            FMT_S: begin
                word      = {fields.imm[11:5], fields.rs2, fields.rs1, fields.funct3,
                             fields.imm[4:0], fields.opcode};
                range_bad = (simm < IMM_I_MIN) || (simm > IMM_I_MAX);
            end
            FMT_B: begin
                word      = {fields.imm[12], fields.imm[10:5], fields.rs2, fields.rs1,
                             fields.funct3, fields.imm[4:1], fields.imm[11], fields.opcode};
                range_bad = (simm < IMM_B_MIN) || (simm > IMM_B_MAX);
                align_bad = fields.imm[0];
            end
            FMT_U: begin
                word      = {fields.imm[31:12], fields.rd, fields.opcode};
                range_bad = |fields.imm[11:0];
            end
            FMT_J: begin
                word      = {fields.imm[20], fields.imm[10:1], fields.imm[11],
                             fields.imm[19:12], fields.rd, fields.opcode};
                range_bad = (simm < IMM_J_MIN) || (simm > IMM_J_MAX);
                align_bad = fields.imm[0];
            end
            default: fmt_bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_encoder_loader.sv
// Packs streamed instruction fields into RV32I words and writes them to IMEM.
// ENC_RANGE_CHECK_EN enables immediate range/alignment rejection.
module inst_encoder_loader
    import riscv_enc_pkg::*;
#(
    parameter int unsigned IMEM_AW   = 14,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_fmt,
    input  logic [6:0]         in_opcode,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [2:0]         in_funct3,
    input  logic [6:0]         in_funct7,
    input  logic [31:0]        in_imm,
    output logic               imem_we,
    input  logic               imem_ready,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_din,
    output logic               full,
    output logic               err,
    output logic [1:0]         err_code,
    output logic [IMEM_AW:0]   count
);

    localparam int unsigned        CNT_W     = IMEM_AW + 1;
    localparam logic [IMEM_AW-1:0] ADDR_LAST = '1;
    localparam logic [IMEM_AW-1:0] ADDR_BASE = IMEM_AW'(BASE_ADDR);
`ifdef ENC_RANGE_CHECK_EN
    localparam logic RANGE_CHECK = 1'b1;
`else
    localparam logic RANGE_CHECK = 1'b0;
`endif

    state_t       state, state_nxt;
    inst_fields_t fields;
    logic [31:0]  word;
    logic         fmt_bad, range_bad, align_bad;
    logic         accept, wr_done, last, reject;
    logic [1:0]   rej_code;

    assign fields.imm    = in_imm;
    assign fields.funct7 = in_funct7;
    assign fields.rs2    = in_rs2;
    assign fields.rs1    = in_rs1;
    assign fields.funct3 = in_funct3;
    assign fields.rd     = in_rd;
    assign fields.opcode = in_opcode;

    inst_field_pack u_pack (
        .fmt       (in_fmt),
        .fields    (fields),
        .word      (word),
        .fmt_bad   (fmt_bad),
        .range_bad (range_bad),
        .align_bad (align_bad)
    );

    assign accept  = in_valid & in_ready;
    assign wr_done = imem_we & imem_ready;
    assign last    = (imem_addr == ADDR_LAST);
    assign reject  = fmt_bad | (RANGE_CHECK & (range_bad | align_bad));

    always_comb begin
        rej_code = ERR_ALIGN;
        if (fmt_bad)        rej_code = ERR_FMT;
        else if (range_bad) rej_code = ERR_RANGE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start)                                      state_nxt = ST_LOAD;
        else if (state == ST_LOAD && wr_done && last)   state_nxt = ST_FULL;
    end

    // A write pending to the last address blocks intake so nothing is accepted past the end.
    always_comb begin
        in_ready = (state == ST_LOAD) & ~start & (~imem_we | (imem_ready & ~last));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we   <= 1'b0;
            imem_addr <= ADDR_BASE;
            imem_din  <= '0;
            full      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            count     <= '0;
        end else if (start) begin
            imem_we   <= 1'b0;
            imem_addr <= ADDR_BASE;
            full      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            count     <= '0;
        end else begin
            if (wr_done) begin
                imem_we <= 1'b0;
                count   <= count + CNT_W'(1);
                if (last) full      <= 1'b1;
                else      imem_addr <= imem_addr + IMEM_AW'(1);
            end
            if (accept) begin
                if (reject) begin
                    err <= 1'b1;
                    if (err_code == ERR_NONE) err_code <= rej_code;
                end else begin
                    imem_we  <= 1'b1;
                    imem_din <= word;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed bench for inst_encoder_loader (4-word IMEM) with a behavioural model.
module tb_inst_encoder_loader;
    import riscv_enc_pkg::*;

    localparam int unsigned AW   = 2;
    localparam int unsigned BASE = 0;
    localparam int unsigned MAXA = (1 << AW) - 1;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, imem_ready = 1'b1;
    logic [2:0]    in_fmt = '0, in_funct3 = '0;
    logic [6:0]    in_opcode = '0, in_funct7 = '0;
    logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0]   in_imm = '0;
    logic          in_ready, imem_we, full, err;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_din;
    logic [1:0]    err_code;
    logic [AW:0]   count;

    int errors = 0, checks = 0;

    inst_encoder_loader #(.IMEM_AW(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_din(imem_din),
        .full(full), .err(err), .err_code(err_code), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: 0 idle, 1 loading, 2 full.
    int          m_state;
    bit          m_we, m_full, m_err, m_acc;
    int unsigned m_addr, m_count, m_code;
    bit [31:0]   m_din, m_w;
    int          m_c, m_acc_cnt;

    function automatic bit m_rdy();
        return (m_state == 1) && !start && (!m_we || (imem_ready && m_addr != MAXA));
    endfunction

    // Field placement by shifts and masks, straight from the RV32I formats.
    function automatic void m_encode(input int unsigned fmt, op, rd, rs1, rs2, f3, f7,
                                     input int imm, output bit [31:0] w, output int code);
        int unsigned u;
        u = imm;
        w = 0;
        code = 0;
        case (fmt)
            0: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            1: w = ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            2: w = (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                   | ((u & 32'h1F) << 7) | op;
            3: w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20)
                   | (rs1 << 15) | (f3 << 12) | (((u >> 1) & 32'hF) << 8)
                   | (((u >> 11) & 1) << 7) | op;
            4: w = (u & 32'hFFFFF000) | (rd << 7) | op;
            5: w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                   | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12) | (rd << 7) | op;
            default: code = 2;
        endcase
`ifdef ENC_RANGE_CHECK_EN
        if ((fmt == 1 || fmt == 2) && (imm < -2048 || imm > 2047)) code = 1;
        if (fmt == 3) begin
            if (imm < -4096 || imm > 4094) code = 1;
            else if ((u & 1) != 0)         code = 3;
        end
        if (fmt == 5) begin
            if (imm < -(1 << 20) || imm > (1 << 20) - 2) code = 1;
            else if ((u & 1) != 0)                       code = 3;
        end
        if (fmt == 4 && (u & 32'hFFF) != 0) code = 1;
`endif
    endfunction

    initial begin
        m_state = 0; m_we = 0; m_full = 0; m_err = 0; m_addr = BASE; m_count = 0;
        m_code = 0; m_din = 0; m_acc_cnt = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_state = 0; m_we = 0; m_full = 0; m_err = 0; m_addr = BASE;
                m_count = 0; m_code = 0; m_din = 0;
            end else if (start) begin
                m_state = 1; m_we = 0; m_full = 0; m_err = 0; m_addr = BASE;
                m_count = 0; m_code = 0;
            end else begin
                m_acc = in_valid && m_rdy();
                m_encode(32'(in_fmt), 32'(in_opcode), 32'(in_rd), 32'(in_rs1), 32'(in_rs2),
                         32'(in_funct3), 32'(in_funct7), $signed(in_imm), m_w, m_c);
                if (m_we && imem_ready) begin
                    m_we = 0;
                    m_count++;
                    if (m_addr == MAXA) begin m_full = 1; m_state = 2; end
                    else m_addr++;
                end
                if (m_acc) begin
                    m_acc_cnt++;
                    if (m_c == 0) begin m_we = 1; m_din = m_w; end
                    else begin m_err = 1; if (m_code == 0) m_code = 32'(m_c); end
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        #1;
        chk("in_ready", 32'(in_ready), 32'(m_rdy()));
        chk("imem_we", 32'(imem_we), 32'(m_we));
        chk("imem_addr", 32'(imem_addr), m_addr);
        if (m_we) chk("imem_din", imem_din, m_din);
        chk("full", 32'(full), 32'(m_full));
        chk("err", 32'(err), 32'(m_err));
        chk("err_code", 32'(err_code), m_code);
        chk("count", 32'(count), m_count);
    end

    task automatic drive(input int unsigned fmt, op, rd, rs1, rs2, f3, f7, input int imm);
        in_valid  = 1'b1;
        in_fmt    = 3'(fmt);
        in_opcode = 7'(op);
        in_rd     = 5'(rd);
        in_rs1    = 5'(rs1);
        in_rs2    = 5'(rs2);
        in_funct3 = 3'(f3);
        in_funct7 = 7'(f7);
        in_imm    = 32'(imm);
    endtask

    task automatic wait_acc(input string name);
        int n0;
        n0 = m_acc_cnt;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_acc_cnt != n0) break;
        end
        if (m_acc_cnt == n0) begin
            checks++;
            errors++;
            $display("FAIL accept_%s: bundle not taken within 20 cycles", name);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic lit_reset(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_we"}, 32'(imem_we), 32'd0);
        chk({tag, "_addr"}, 32'(imem_addr), BASE);
        chk({tag, "_din"}, imem_din, 32'd0);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_code"}, 32'(err_code), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2;
        lit_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();

        // Back-to-back writes: addi, sw, beq
        drive(FMT_I, OP_IMM, 1, 0, 0, 0, 0, 5);
        wait_acc("addi");
        #2;
        chk("addi_we", 32'(imem_we), 32'd1);
        chk("addi_addr", 32'(imem_addr), 32'd0);
        chk("addi_din", imem_din, 32'h00500093);
        drive(FMT_S, OP_STORE, 0, 1, 2, 2, 0, 8);
        wait_acc("sw");
        #2;
        chk("sw_din", imem_din, 32'h0020A423);
        chk("sw_addr", 32'(imem_addr), 32'd1);
        chk("sw_count", 32'(count), 32'd1);
        drive(FMT_B, OP_BRANCH, 0, 0, 0, 0, 0, -4);
        wait_acc("beq");
        #2;
        chk("beq_din", imem_din, 32'hFE000EE3);

        // IMEM back-pressure for 3 cycles with jal waiting
        imem_ready = 1'b0;
        drive(FMT_J, OP_JAL, 1, 0, 0, 0, 0, 2048);
        repeat (3) begin
            @(negedge clk);
            #2;
            chk("stall_we", 32'(imem_we), 32'd1);
            chk("stall_addr", 32'(imem_addr), 32'd2);
            chk("stall_din", imem_din, 32'hFE000EE3);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        imem_ready = 1'b1;
        wait_acc("jal");
        #2;
        chk("jal_din", imem_din, 32'h001000EF);
        chk("jal_addr", 32'(imem_addr), 32'd3);
        chk("jal_count", 32'(count), 32'd3);

        // Fifth bundle must be ignored once the last address is written
        drive(FMT_I, OP_IMM, 1, 0, 0, 0, 0, 5);
        repeat (4) begin
            @(negedge clk);
            #2;
            chk("full_we", 32'(imem_we), 32'd0);
            chk("full_flag", 32'(full), 32'd1);
            chk("full_in_ready", 32'(in_ready), 32'd0);
        end
        chk("full_count", 32'(count), 32'd4);

        // Restart with a bundle present in the start cycle: not taken that cycle
        start = 1'b1;
        @(negedge clk);
        #2;
        chk("restart_addr", 32'(imem_addr), 32'd0);
        chk("restart_count", 32'(count), 32'd0);
        chk("restart_full", 32'(full), 32'd0);
        chk("restart_we", 32'(imem_we), 32'd0);
        start = 1'b0;
        wait_acc("addi2");
        #2;
        chk("addi2_din", imem_din, 32'h00500093);

        // Immediate out of range for I-format
        drive(FMT_I, OP_IMM, 1, 0, 0, 0, 0, 2048);
        wait_acc("imm2048");
        #2;
`ifdef ENC_RANGE_CHECK_EN
        chk("imm2048_we", 32'(imem_we), 32'd0);
        chk("imm2048_err", 32'(err), 32'd1);
        chk("imm2048_code", 32'(err_code), 32'd1);
`else
        chk("imm2048_we", 32'(imem_we), 32'd1);
        chk("imm2048_din", imem_din, 32'h80000093);
        chk("imm2048_err", 32'(err), 32'd0);
`endif
        chk("imm2048_addr", 32'(imem_addr), 32'd1);
        drive(FMT_I, OP_IMM, 1, 0, 0, 0, 0, 2047);
        wait_acc("imm2047");
        #2;
        chk("imm2047_din", imem_din, 32'h7FF00093);
        drive(6, OP_IMM, 1, 0, 0, 0, 0, 0);
        wait_acc("fmt6");
        in_valid = 1'b0;
        #2;
        chk("fmt6_err", 32'(err), 32'd1);
`ifdef ENC_RANGE_CHECK_EN
        chk("fmt6_code", 32'(err_code), 32'd1);
`else
        chk("fmt6_code", 32'(err_code), 32'd2);
`endif
        repeat (2) @(negedge clk);
        pulse_start();

        // Branch/jump boundaries and alignment
        drive(FMT_B, OP_BRANCH, 0, 3, 4, 1, 0, 3);
        wait_acc("b_odd");
        #2;
`ifdef ENC_RANGE_CHECK_EN
        chk("b_odd_code", 32'(err_code), 32'd3);
`else
        chk("b_odd_err", 32'(err), 32'd0);
`endif
        drive(FMT_B, OP_BRANCH, 0, 3, 4, 1, 0, -4096);
        wait_acc("b_min");
        drive(FMT_J, OP_JAL, 1, 0, 0, 0, 0, 1048574);
        wait_acc("j_max");
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        pulse_start();

        drive(FMT_J, OP_JAL, 1, 0, 0, 0, 0, 1048576);
        wait_acc("j_over");
        drive(FMT_U, OP_LUI, 5, 0, 0, 0, 0, 32'h12345000);
        wait_acc("lui");
        drive(FMT_U, OP_LUI, 5, 0, 0, 0, 0, 32'h12345001);
        wait_acc("lui_low");
        drive(FMT_S, OP_STORE, 0, 1, 2, 2, 0, -2048);
        wait_acc("s_min");
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        pulse_start();

        // Start discards a stalled write
        imem_ready = 1'b0;
        drive(FMT_R, OP_OP, 3, 1, 2, 0, 0, 0);
        wait_acc("add");
        in_valid = 1'b0;
        #2;
        chk("add_din", imem_din, 32'h002081B3);
        chk("add_we", 32'(imem_we), 32'd1);
        pulse_start();
        #2;
        chk("discard_we", 32'(imem_we), 32'd0);
        chk("discard_addr", 32'(imem_addr), 32'd0);
        imem_ready = 1'b1;

        // Asynchronous reset during a held write
        drive(FMT_R, OP_OP, 3, 1, 2, 0, 32, 0);
        wait_acc("sub");
        in_valid = 1'b0;
        imem_ready = 1'b0;
        #2;
        chk("sub_din", imem_din, 32'h402081B3);
        #1;
        rst_n = 1'b0;
        #1;
        lit_reset("midrst");
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        imem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        lit_reset("idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
